// File: rtl/out_bram_drain_ctrl_pkg.sv
// Shared constants and FSM encoding for the output BRAM drain controller.
package out_bram_drain_ctrl_pkg;

   localparam int BRAM_DEPTH_OUT      = 1024;
   localparam int LOG2_BRAM_DEPTH_OUT = 10;
   localparam int RESULTS_SMALL       = 512;
   localparam int RESULTS_LARGE       = 2048;
   localparam int WPF_SMALL           = RESULTS_SMALL / 2;
   localparam int WPF_LARGE           = RESULTS_LARGE / 2;

   typedef enum logic [1:0] {
      ST_COLLECT  = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_IDLE_ERR = 2'd3
   } state_e;

endpackage

// File: rtl/out_bram_drain_ctrl_bram.sv
// Simple dual-port BRAM: one synchronous write port, one read port with 1-cycle latency.
module out_bram_drain_ctrl_bram #(
   parameter int DATA_WIDTH = 256,
   parameter int DEPTH      = 1024,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/out_bram_drain_ctrl.sv
// Packs 128-bit result pairs into a BRAM frame, then drains the frame to the host
// through a 2-entry skid buffer.
module out_bram_drain_ctrl
   import out_bram_drain_ctrl_pkg::*;
#(
   parameter int DEPTH      = BRAM_DEPTH_OUT,
   parameter int ADDR_WIDTH = LOG2_BRAM_DEPTH_OUT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   mode,
   input  logic [127:0] res_in,
   input  logic         res_vld,
   output logic [255:0] interface_out,
   output logic         output_vld,
   input  logic         output_ready,
   output logic [1:0]   state,
   output logic         frame_done,
   output logic         overflow
);

   localparam logic [ADDR_WIDTH-1:0] LAST_SMALL = ADDR_WIDTH'(WPF_SMALL - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_LARGE = ADDR_WIDTH'(WPF_LARGE - 1);

   state_e                  state_q;
   logic                    armed_q, wide_q, half_q;
   logic [127:0]            hold_q;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, rd_addr_q, out_cnt_q;
   logic                    rd_all_q, pend_q;
   logic [1:0]              cnt_q;
   logic [255:0]            out_q, skid_q;
   logic                    frame_done_q, overflow_q;
   logic [255:0]            bram_rdata;

   // Until the first clock after reset the live mode pin stands in for the latched one.
   logic                    wide_eff;
   logic [ADDR_WIDTH-1:0]   last_addr;
   logic                    in_collect, wr_en, pop, rd_en, last_xfer;
   logic [1:0]              occ;

   assign wide_eff   = armed_q ? wide_q : (mode != 2'd0);
   assign last_addr  = wide_eff ? LAST_LARGE : LAST_SMALL;
   assign in_collect = (state_q == ST_COLLECT);
   assign wr_en      = in_collect && res_vld && half_q;

   // output_vld/output_ready: a word moves on every rising edge where both are high;
   // while output_vld is high and output_ready low, interface_out holds its value.
   assign pop       = output_vld && output_ready;
   assign occ       = cnt_q + {1'b0, pend_q} - {1'b0, pop};
   assign rd_en     = (state_q == ST_DRAIN) && !rd_all_q && (occ < 2'd2);
   assign last_xfer = pop && (out_cnt_q == last_addr);

   out_bram_drain_ctrl_bram #(
      .DATA_WIDTH(256),
      .DEPTH     (DEPTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_bram (
      .clk_i  (clk),
      .we_i   (wr_en),
      .waddr_i(wr_addr_q),
      .wdata_i({res_in, hold_q}),
      .re_i   (rd_en),
      .raddr_i(rd_addr_q),
      .rdata_o(bram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_COLLECT;
         armed_q      <= 1'b0;
         wide_q       <= 1'b0;
         half_q       <= 1'b0;
         hold_q       <= '0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         out_cnt_q    <= '0;
         rd_all_q     <= 1'b0;
         pend_q       <= 1'b0;
         cnt_q        <= 2'd0;
         out_q        <= '0;
         skid_q       <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         pend_q       <= rd_en;
         if (res_vld && !in_collect) overflow_q <= 1'b1;
         if (!armed_q) begin
            armed_q <= 1'b1;
            wide_q  <= (mode != 2'd0);
         end

         case (state_q)
            ST_COLLECT: begin
               if (res_vld) begin
                  if (!half_q) begin
                     hold_q <= res_in;
                     half_q <= 1'b1;
                  end else begin
                     half_q <= 1'b0;
                     if (wr_addr_q == last_addr) begin
                        wr_addr_q <= '0;
                        state_q   <= ST_DRAIN;
                     end else begin
                        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (rd_en) begin
                  if (rd_addr_q == last_addr) rd_all_q <= 1'b1;
                  else rd_addr_q <= rd_addr_q + ADDR_WIDTH'(1);
               end
               if (last_xfer) begin
                  frame_done_q <= 1'b1;
                  rd_addr_q    <= '0;
                  rd_all_q     <= 1'b0;
                  wide_q       <= (mode != 2'd0);
                  state_q      <= ST_COLLECT;
               end
            end
            default: state_q <= ST_COLLECT;
         endcase

         if (pop) out_cnt_q <= (out_cnt_q == last_addr) ? '0 : out_cnt_q + ADDR_WIDTH'(1);

         // out_q is the head entry and drives interface_out; skid_q is the second slot.
         if (pend_q && !pop) begin
            if (cnt_q == 2'd0) out_q <= bram_rdata;
            else skid_q <= bram_rdata;
            cnt_q <= cnt_q + 2'd1;
         end else if (!pend_q && pop) begin
            out_q <= skid_q;
            cnt_q <= cnt_q - 2'd1;
         end else if (pend_q && pop) begin
            if (cnt_q == 2'd1) begin
               out_q <= bram_rdata;
            end else begin
               out_q  <= skid_q;
               skid_q <= bram_rdata;
            end
         end
      end
   end

   assign interface_out = out_q;
   assign output_vld    = (cnt_q != 2'd0);
   assign state         = state_q;
   assign frame_done    = frame_done_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_out_bram_drain_ctrl.sv
// Self-checking bench for out_bram_drain_ctrl against a frame-level reference model.
module tb_out_bram_drain_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [1:0]   mode = 2'd0;
   logic [127:0] res_in = '0;
   logic         res_vld = 1'b0;
   logic         output_ready = 1'b0;
   logic [255:0] interface_out;
   logic         output_vld;
   logic [1:0]   state;
   logic         frame_done;
   logic         overflow;

   out_bram_drain_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .mode         (mode),
      .res_in       (res_in),
      .res_vld      (res_vld),
      .interface_out(interface_out),
      .output_vld   (output_vld),
      .output_ready (output_ready),
      .state        (state),
      .frame_done   (frame_done),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [255:0] exp_q[$];
   logic [255:0] got_q[$];
   logic [127:0] pend_res[$];
   int           model_wpf = 256;

   int           coll_cycles, stall_bad, done_cnt;
   bit           done_after, timeout;
   logic [1:0]   state_after;

   // Reference model: results accumulate until a full frame exists, then become words.
   task automatic model_result(input logic [127:0] r);
      pend_res.push_back(r);
      if (pend_res.size() == 2 * model_wpf) begin
         for (int k = 0; k < model_wpf; k++) exp_q.push_back({pend_res[2*k+1], pend_res[2*k]});
         pend_res.delete();
      end
   endtask

   task automatic send_results(input int n, input bit use_index, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         if (gap_pct > 0)
            while ($urandom_range(0, 99) < gap_pct) begin
               @(posedge clk); #1;
            end
         res_vld = 1'b1;
         res_in  = use_index ? 128'(i) : {$urandom(), $urandom(), $urandom(), $urandom()};
         model_result(res_in);
         @(posedge clk); #1;
         res_vld = 1'b0;
      end
   endtask

   // Collects n words; next_mode is what the DUT should latch on its return to COLLECT.
   task automatic collect(input int n, input int ready_pct, input logic [1:0] next_mode);
      bit           held;
      logic [255:0] held_w;
      got_q.delete();
      stall_bad = 0; done_cnt = 0; timeout = 0; coll_cycles = 0;
      held = 1'b0; held_w = '0;
      mode = next_mode;
      while (got_q.size() < n) begin
         if (coll_cycles >= 4 * n + 50) begin
            timeout = 1;
            break;
         end
         if (held && (!output_vld || interface_out !== held_w)) stall_bad++;
         if (frame_done) done_cnt++;
         output_ready = ($urandom_range(0, 99) < ready_pct);
         held   = output_vld && !output_ready;
         held_w = interface_out;
         if (output_vld && output_ready) got_q.push_back(interface_out);
         @(posedge clk); #1;
         coll_cycles++;
      end
      output_ready = 1'b0;
      done_after  = frame_done;
      state_after = state;
      if (frame_done) done_cnt++;
      model_wpf = (next_mode == 2'd0) ? 256 : 1024;
      @(posedge clk); #1;
      if (frame_done) done_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
      n_cmp++; if (output_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %b want 0", output_vld); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
      n_cmp++; if (interface_out !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", interface_out); end
      rst = 1'b0;
      pend_res.delete(); exp_q.delete();
      model_wpf = (mode == 2'd0) ? 256 : 1024;
      @(posedge clk); #1;
   endtask

   task automatic test_index_frame();
      int n;
      send_results(512, 1'b1, 0);
      n = exp_q.size();
      collect(n, 100, 2'd3);
      n_cmp++; if (got_q.size() != 256) begin n_bad++; $display("FAIL s1_count: got %0d want 256", got_q.size()); end
      foreach (got_q[i]) if (i < n) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL s1_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (coll_cycles != 258) begin n_bad++; $display("FAIL s1_cycles: got %0d want 258", coll_cycles); end
      n_cmp++; if (done_cnt != 1 || !done_after) begin n_bad++; $display("FAIL s1_done: got %0d pulses (after=%b) want 1", done_cnt, done_after); end
      n_cmp++; if (state_after !== 2'd0) begin n_bad++; $display("FAIL s1_state_end: got %0d want 0", state_after); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL s1_ovf: got %b want 0", overflow); end
      exp_q.delete();
   endtask

   task automatic test_drain_latency();
      int n;
      send_results(2048, 1'b0, 20);
      n = exp_q.size();
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL s2_drain_entry: got %0d want 1", state); end
      n_cmp++; if (output_vld !== 1'b0) begin n_bad++; $display("FAIL s2_vld_c0: got %b want 0", output_vld); end
      @(posedge clk); #1;
      n_cmp++; if (output_vld !== 1'b0) begin n_bad++; $display("FAIL s2_vld_c1: got %b want 0", output_vld); end
      @(posedge clk); #1;
      n_cmp++; if (output_vld !== 1'b1) begin n_bad++; $display("FAIL s2_vld_c2: got %b want 1", output_vld); end
      collect(n, 100, 2'd1);
      n_cmp++; if (got_q.size() != 1024) begin n_bad++; $display("FAIL s2_count: got %0d want 1024", got_q.size()); end
      foreach (got_q[i]) if (i < n) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL s2_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (done_cnt != 1 || !done_after) begin n_bad++; $display("FAIL s2_done: got %0d pulses (after=%b) want 1", done_cnt, done_after); end
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      int n;
      send_results(2048, 1'b0, 0);
      n = exp_q.size();
      collect(n, 50, 2'd0);
      n_cmp++; if (got_q.size() != 1024 || timeout) begin n_bad++; $display("FAIL s3_count: got %0d want 1024", got_q.size()); end
      foreach (got_q[i]) if (i < n) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL s3_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL s3_stall_stable: got %0d unstable stalls want 0", stall_bad); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL s3_done: got %0d pulses want 1", done_cnt); end
      exp_q.delete();
   endtask

   task automatic test_overflow();
      int n;
      send_results(512, 1'b0, 10);
      n = exp_q.size();
      res_vld = 1'b1;
      res_in  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      res_vld = 1'b0;
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL s4_ovf_set: got %b want 1", overflow); end
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL s4_state_hold: got %0d want 1", state); end
      collect(n, 70, 2'd0);
      n_cmp++; if (got_q.size() != 256) begin n_bad++; $display("FAIL s4_count: got %0d want 256", got_q.size()); end
      foreach (got_q[i]) if (i < n) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL s4_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL s4_ovf_sticky: got %b want 1", overflow); end
      exp_q.delete();
   endtask

   task automatic test_mid_frame_reset();
      int n;
      send_results(301, 1'b0, 0);
      rst = 1'b1;
      #2;
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL s5_state: got %0d want 0", state); end
      n_cmp++; if (output_vld !== 1'b0) begin n_bad++; $display("FAIL s5_vld: got %b want 0", output_vld); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL s5_ovf: got %b want 0", overflow); end
      n_cmp++; if (interface_out !== '0) begin n_bad++; $display("FAIL s5_data: got %h want 0", interface_out); end
      n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL s5_done: got %b want 0", frame_done); end
      @(posedge clk); #1;
      rst = 1'b0;
      pend_res.delete(); exp_q.delete();
      model_wpf = (mode == 2'd0) ? 256 : 1024;
      send_results(512, 1'b0, 0);
      n = exp_q.size();
      collect(n, 100, 2'd0);
      n_cmp++; if (got_q.size() != 256) begin n_bad++; $display("FAIL s5_count: got %0d want 256", got_q.size()); end
      foreach (got_q[i]) if (i < n) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL s5_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int n;
      send_results(100, 1'b0, 0);
      mode = 2'd2;
      send_results(412, 1'b0, 0);
      n = exp_q.size();
      collect(n, 80, 2'd2);
      n_cmp++; if (got_q.size() != 256 || n != 256) begin n_bad++; $display("FAIL s6_f1_count: got %0d want 256", got_q.size()); end
      foreach (got_q[i]) if (i < n) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL s6_f1_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      exp_q.delete();
      send_results(1000, 1'b0, 0);
      mode = 2'd0;
      send_results(1048, 1'b0, 0);
      n = exp_q.size();
      collect(n, 80, 2'd0);
      n_cmp++; if (got_q.size() != 1024 || n != 1024) begin n_bad++; $display("FAIL s6_f2_count: got %0d want 1024", got_q.size()); end
      foreach (got_q[i]) if (i < n) begin
         n_cmp++;
         if (got_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL s6_f2_word[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      n_cmp++; if (state !== 2'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL s6_end: got state %0d ovf %b want 0/0", state, overflow); end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_index_frame();
      test_drain_latency();
      test_backpressure();
      test_overflow();
      test_mid_frame_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
